// File: rtl/integ_pkg.sv
// -----------------------------------------------------------------------------
// integ_pkg
// Shared constants, FSM state type and the quotient-to-sample decode helper for
// the receive side of the 25x accumulate-and-dump integrator.
//   YW      : width of the incoming running window sum
//   XW      : width of the recovered sample
//   DIVISOR : integrator gain divided back out
//   DW      : dividend width, also the number of divider iterations
//   RW      : divider remainder width (must hold 2*DIVISOR-1)
// -----------------------------------------------------------------------------
package integ_pkg;

   localparam int YW      = 32'd13;
   localparam int XW      = 32'd4;
   localparam int DIVISOR = 32'd25;
   localparam int DW      = 32'd9;
   localparam int XMAX    = (32'd1 << XW) - 32'd1;
   localparam int RW      = $clog2(DIVISOR) + 32'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [XW-1:0] x;
      logic          err;
   } dec_t;

   // Map a finished quotient/remainder pair onto the output sample and flag.
   // A quotient too large for XW bits saturates; a non-zero remainder keeps
   // the truncated quotient but marks the sample as not cleanly decoded.
   function automatic dec_t decode_quotient(input logic [DW-1:0] quo,
                                            input logic [RW-1:0] rem);
      dec_t res;
      if (quo > DW'(XMAX)) begin
         res.x   = XW'(XMAX);
         res.err = 1'b1;
      end else begin
         res.x   = quo[XW-1:0];
         res.err = (rem != {RW{1'b0}});
      end
      return res;
   endfunction

endpackage

// File: rtl/integ_diff_decoder_if.sv
// -----------------------------------------------------------------------------
// integ_diff_decoder_if
// Handshake bundle between the integrator link, the decoder and the consumer.
//   in_valid/in_ready/y/win_start : window-sum input channel
//   out_valid/out_ready/x/err     : recovered-sample output channel
// master : the environment (drives sums, accepts samples)
// slave  : the decoder
// -----------------------------------------------------------------------------
interface integ_diff_decoder_if;
   import integ_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [YW-1:0] y;
   logic          win_start;
   logic          out_valid;
   logic          out_ready;
   logic [XW-1:0] x;
   logic          err;

   modport master (
      output in_valid, y, win_start, out_ready,
      input  in_ready, out_valid, x, err
   );

   modport slave (
      input  in_valid, y, win_start, out_ready,
      output in_ready, out_valid, x, err
   );

endinterface

// File: rtl/const_div_serial.sv
// -----------------------------------------------------------------------------
// const_div_serial
// Serial restoring divider by a constant: one quotient bit per clock.
//   clk, reset : clock, asynchronous active-low reset
//   start      : load dividend, clear remainder/quotient, begin DW iterations
//   dividend   : DW-bit value to divide
//   busy       : iterations still outstanding
//   done       : one-cycle pulse after the last iteration
//   quotient   : DW-bit quotient (valid with done)
//   remainder  : RW-bit remainder (valid with done)
// -----------------------------------------------------------------------------
module const_div_serial #(
   parameter int DW      = 32'd9,
   parameter int DIVISOR = 32'd25,
   parameter int RW      = $clog2(DIVISOR) + 32'd1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [RW-1:0] remainder
);

   localparam int            CW       = $clog2(DW + 32'd1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
   localparam logic [RW-1:0] DIV_C    = RW'(DIVISOR);

   logic [DW-1:0] dvd_r;
   logic [DW-1:0] quo_r;
   logic [RW-1:0] rem_r;
   logic [CW-1:0] cnt_r;
   logic          done_r;
   logic [RW-1:0] trial_s;
   logic [RW-1:0] rem_nxt_s;
   logic          qbit_s;

   // One restoring step: bring down the next dividend bit, subtract if it fits.
   // rem_r < DIVISOR always, so the shifted trial fits in RW bits.
   always_comb begin
      trial_s   = {rem_r[RW-2:0], dvd_r[DW-1]};
      rem_nxt_s = trial_s;
      qbit_s    = 1'b0;
      if (trial_s >= DIV_C) begin
         rem_nxt_s = trial_s - DIV_C;
         qbit_s    = 1'b1;
      end else begin
         rem_nxt_s = trial_s;
         qbit_s    = 1'b0;
      end
   end

   // Divider state: load on start, iterate while the counter is non-zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_r  <= {DW{1'b0}};
         quo_r  <= {DW{1'b0}};
         rem_r  <= {RW{1'b0}};
         cnt_r  <= {CW{1'b0}};
         done_r <= 1'b0;
      end else if (start) begin
         dvd_r  <= dividend;
         quo_r  <= {DW{1'b0}};
         rem_r  <= {RW{1'b0}};
         cnt_r  <= CNT_LOAD;
         done_r <= 1'b0;
      end else if (cnt_r != {CW{1'b0}}) begin
         dvd_r  <= {dvd_r[DW-2:0], 1'b0};
         quo_r  <= {quo_r[DW-2:0], qbit_s};
         rem_r  <= rem_nxt_s;
         cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
         done_r <= (cnt_r == {{(CW-1){1'b0}}, 1'b1});
      end else begin
         done_r <= 1'b0;
      end
   end

   assign busy      = (cnt_r != {CW{1'b0}});
   assign done      = done_r;
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/integ_diff_decoder.sv
// -----------------------------------------------------------------------------
// integ_diff_decoder
// Recovers integrator input samples x = (y[n] - y[n-1]) / DIVISOR from a
// stream of running window sums, flagging sums that do not decode cleanly.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of integ_diff_decoder_if
//           in_valid/in_ready/y/win_start  - window-sum input
//           out_valid/out_ready/x/err      - recovered-sample output
// Clean path: out_valid rises DW+1 edges after acceptance.
// Invalid difference (negative or wider than DW bits): out_valid rises one
// edge after acceptance with x=0, err=1.
// -----------------------------------------------------------------------------
module integ_diff_decoder
   import integ_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   integ_diff_decoder_if.slave  bus
);

   state_t        state_r;
   state_t        state_nxt;
   logic [YW-1:0] prev_y_r;
   logic [YW-1:0] prev_y_nxt;
   logic [XW-1:0] x_r;
   logic [XW-1:0] x_nxt;
   logic          err_r;
   logic          err_nxt;
   logic          out_valid_r;
   logic          out_valid_nxt;
   logic          in_ready_r;
   logic          in_ready_nxt;

   logic [YW-1:0] base_s;
   logic [YW:0]   diff_s;
   logic          neg_s;
   logic          big_s;
   logic          start_s;
   logic          div_busy_s;
   logic          div_done_s;
   logic [DW-1:0] quo_s;
   logic [RW-1:0] rem_s;
   dec_t          dec_s;

   // Difference against the previous sum, one bit wider so negatives show up
   // in the sign bit instead of wrapping.
   always_comb begin
      if (bus.win_start) begin
         base_s = {YW{1'b0}};
      end else begin
         base_s = prev_y_r;
      end
      diff_s = {1'b0, bus.y} - {1'b0, base_s};
      neg_s  = diff_s[YW];
      big_s  = |diff_s[YW-1:DW];
      dec_s  = decode_quotient(quo_s, rem_s);
   end

   const_div_serial #(
      .DW      (DW),
      .DIVISOR (DIVISOR),
      .RW      (RW)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (start_s),
      .dividend  (diff_s[DW-1:0]),
      .busy      (div_busy_s),
      .done      (div_done_s),
      .quotient  (quo_s),
      .remainder (rem_s)
   );

   // Next-state and output-register logic for the IDLE/DIV/DONE sequence.
   always_comb begin
      state_nxt     = state_r;
      prev_y_nxt    = prev_y_r;
      x_nxt         = x_r;
      err_nxt       = err_r;
      out_valid_nxt = out_valid_r;
      start_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               // The previous sum tracks every accepted y, even undecodable ones.
               prev_y_nxt = bus.y;
               if (neg_s || big_s) begin
                  // Fast error path: outputs staged now, out_valid raised in DONE.
                  state_nxt = DONE;
                  x_nxt     = {XW{1'b0}};
                  err_nxt   = 1'b1;
               end else begin
                  state_nxt = DIV;
                  start_s   = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         DIV: begin
            // done pulses as the iteration counter reaches zero.
            if (div_done_s && !div_busy_s) begin
               state_nxt     = DONE;
               x_nxt         = dec_s.x;
               err_nxt       = dec_s.err;
               out_valid_nxt = 1'b1;
            end else begin
               state_nxt = DIV;
            end
         end
         DONE: begin
            if (!out_valid_r) begin
               // Arrived by the fast error path.
               out_valid_nxt = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt     = IDLE;
            out_valid_nxt = 1'b0;
         end
      endcase
      in_ready_nxt = (state_nxt == IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         prev_y_r    <= {YW{1'b0}};
         x_r         <= {XW{1'b0}};
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt;
         prev_y_r    <= prev_y_nxt;
         x_r         <= x_nxt;
         err_r       <= err_nxt;
         out_valid_r <= out_valid_nxt;
         in_ready_r  <= in_ready_nxt;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.x         = x_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_integ_diff_decoder.sv
// -----------------------------------------------------------------------------
// tb_integ_diff_decoder
// Directed stimulus with hand-computed expectations, plus a per-cycle
// comparison against a behavioural model of the decoder.
// -----------------------------------------------------------------------------
module tb_integ_diff_decoder;

   logic clk;
   logic reset;
   integ_diff_decoder_if bus();

   integ_diff_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural decode: plain integer arithmetic.
   // lat = edges from acceptance until out_valid is high.
   function automatic void model(input int prev, input int yv, input bit ws,
                                 output int ex, output int ee, output int lat);
      int d;
      d = yv - (ws ? 0 : prev);
      if (d < 0 || d > 511) begin
         ex = 0; ee = 1; lat = 1;
      end else begin
         lat = 10;
         if (d / 25 > 15) begin
            ex = 15; ee = 1;
         end else begin
            ex = d / 25; ee = (d % 25 != 0) ? 1 : 0;
         end
      end
   endfunction

   // ---------------- per-cycle model comparison ----------------
   int m_prev   = 0;
   bit m_active = 1'b0;
   int m_due    = 0;
   int m_x      = 0;
   int m_err    = 0;
   int ncyc     = 0;

   // Compare DUT outputs to the model on every falling edge.
   always @(negedge clk) begin
      bit exp_ov;
      bit was_idle;
      int lat;
      if (!reset) begin
         m_active = 1'b0;
         m_prev   = 0;
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_in_ready", bus.in_ready, 1);
         chk("rst_x", bus.x, 0);
         chk("rst_err", bus.err, 0);
      end else begin
         exp_ov = m_active && (ncyc >= m_due);
         chk("mdl_out_valid", bus.out_valid, exp_ov);
         chk("mdl_in_ready", bus.in_ready, !m_active);
         if (exp_ov) begin
            chk("mdl_x", bus.x, m_x);
            chk("mdl_err", bus.err, m_err);
         end
         was_idle = !m_active;
         if (exp_ov && bus.out_ready) begin
            m_active = 1'b0;
         end
         if (was_idle && bus.in_valid) begin
            model(m_prev, int'(bus.y), bus.win_start, m_x, m_err, lat);
            m_prev   = int'(bus.y);
            m_active = 1'b1;
            m_due    = ncyc + 1 + lat;
         end
      end
      ncyc++;
   end

   // ---------------- directed driver helpers ----------------
   task automatic drive(input int yv, input bit ws);
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.y         = yv[12:0];
      bus.win_start = ws;
   endtask

   // Wait for acceptance, then drop in_valid just after the accept edge.
   task automatic wait_accept(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({nm, "_accept_timeout"}, 0, 1);
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.win_start = 1'b0;
   endtask

   // Called just after the accept edge; checks latency and the literal result.
   task automatic wait_out(input string nm, input int elat, input int ex, input int ee);
      int seen;
      seen = -1;
      for (int i = 0; i <= 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = i;
            break;
         end
      end
      chk({nm, "_latency"}, seen, elat);
      chk({nm, "_x"}, bus.x, ex);
      chk({nm, "_err"}, bus.err, ee);
   endtask

   task automatic send(input string nm, input int yv, input bit ws,
                       input int ex, input int ee, input int elat);
      drive(yv, ws);
      wait_accept(nm);
      wait_out(nm, elat, ex, ee);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ex, ee, lat;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.y         = 13'd0;
      bus.win_start = 1'b0;
      bus.out_ready = 1'b1;

      // Pin the model with hand-computed values.
      model(0, 250, 1'b1, ex, ee, lat);
      chk("pin_250_x", ex, 10); chk("pin_250_lat", lat, 10);
      model(250, 260, 1'b0, ex, ee, lat);
      chk("pin_260_x", ex, 0);  chk("pin_260_err", ee, 1);
      model(0, 400, 1'b1, ex, ee, lat);
      chk("pin_400_x", ex, 15); chk("pin_400_err", ee, 1);
      model(250, 100, 1'b0, ex, ee, lat);
      chk("pin_neg_lat", lat, 1);

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Clean window
      send("clean250", 250, 1'b1, 10, 0, 10);
      send("clean375", 375, 1'b0, 5, 0, 10);
      send("clean675", 675, 1'b0, 12, 0, 10);
      send("clean700", 700, 1'b0, 1, 0, 10);

      // Non-multiple of the gain
      send("nm_base", 250, 1'b1, 10, 0, 10);
      send("nonmult", 260, 1'b0, 0, 1, 10);

      // Negative difference, then recovery from the updated previous sum
      send("neg_base", 250, 1'b1, 10, 0, 10);
      send("negative", 100, 1'b0, 0, 1, 1);
      send("after_neg", 125, 1'b0, 1, 0, 10);

      // Saturation and over-range fast path
      send("saturate", 400, 1'b1, 15, 1, 10);
      send("overrange", 600, 1'b1, 0, 1, 1);

      // Backpressure with a pending sum held behind it
      bus.out_ready = 1'b0;
      drive(50, 1'b1);
      wait_accept("bp");
      bus.in_valid  = 1'b1;
      bus.y         = 13'd150;
      bus.win_start = 1'b0;
      wait_out("bp", 10, 2, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_x", bus.x, 2);
         chk("bp_hold_err", bus.err, 0);
         chk("bp_hold_in_ready", bus.in_ready, 0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_accept("bp_pending");
      wait_out("bp_pending", 10, 4, 0);
      @(posedge clk); #1;

      // Reset in the middle of a division
      drive(325, 1'b0);
      wait_accept("mid_rst");
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      send("post_rst", 50, 1'b0, 2, 0, 10);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
